// File: rtl/vga_sprite_pkg.sv
// Shared types and register map for the VGA sprite controller.
// Sprite attribute word order inside a 4-word group: X, Y, W, H.
package vga_sprite_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
    } sprite_attr_t;

    localparam int REG_CTRL        = 0;
    localparam int REG_STATUS      = 1;
    localparam int REG_COLL        = 2;
    localparam int REG_SPR_BASE    = 4;
    localparam int CTRL_COMMIT_BIT = 15;

    function automatic logic [15:0] attr_get(input sprite_attr_t a, input logic [1:0] fld);
        logic [15:0] v;
        case (fld)
            2'd0:    v = a.x;
            2'd1:    v = a.y;
            2'd2:    v = a.w;
            default: v = a.h;
        endcase
        return v;
    endfunction

    function automatic sprite_attr_t attr_put(input sprite_attr_t a, input logic [1:0] fld,
                                              input logic [15:0] v);
        sprite_attr_t r;
        r = a;
        case (fld)
            2'd0:    r.x = v;
            2'd1:    r.y = v;
            2'd2:    r.w = v;
            default: r.h = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vga_sprite_compositor.sv
// Fixed-priority pixel compositor (lowest sprite index wins), registered outputs.
// Optional sticky collision register when VGA_SPRITE_COLLISION_EN is defined.
module vga_sprite_compositor #(
    parameter int NUM_SPRITES = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_SPRITES-1:0]      en_i,
    input  logic [NUM_SPRITES-1:0]      obj_i,
    input  logic [NUM_SPRITES-1:0][15:0] pixel_i,
    input  logic                        coll_clr_i,
    output logic                        is_object_o,
    output logic [15:0]                 pixel_o,
    output logic [NUM_SPRITES-1:0]      coll_o
);

    logic [NUM_SPRITES-1:0] hit_s;
    logic                   obj_d, obj_q;
    logic [15:0]            pix_d, pix_q;

    // Priority select: scan high to low so the lowest opaque index is the last to assign
    always_comb begin
        hit_s = obj_i & en_i;
        obj_d = 1'b0;
        pix_d = 16'h0000;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                obj_d = 1'b1;
                pix_d = pixel_i[i];
            end else begin
                obj_d = obj_d;
                pix_d = pix_d;
            end
        end
    end

    // Composite output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            obj_q <= 1'b0;
            pix_q <= 16'h0000;
        end else begin
            obj_q <= obj_d;
            pix_q <= pix_d;
        end
    end

    assign is_object_o = obj_q;
    assign pixel_o     = pix_q;

`ifdef VGA_SPRITE_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_d, coll_q;

    // Sticky collision bits; a new hit in the read-clear cycle is kept
    always_comb begin
        coll_d = coll_clr_i ? '0 : coll_q;
        if ((hit_s & (hit_s - NUM_SPRITES'(1))) != '0) begin
            coll_d = coll_d | hit_s;
        end else begin
            coll_d = coll_d;
        end
    end

    // Collision register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            coll_q <= '0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll_o = coll_q;
`else
    logic unused_clr_s;
    assign unused_clr_s = coll_clr_i;
    assign coll_o       = '0;
`endif

endmodule

// File: rtl/vga_sprite_ctrl.sv
// Avalon-MM sprite register file with shadow->active commit at VS falling edge,
// plus the pixel compositor. Optional collision logic: VGA_SPRITE_COLLISION_EN.
module vga_sprite_ctrl
    import vga_sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int AW          = 6
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [AW-1:0]                AVL_Address,
    input  logic                         AVL_Read,
    input  logic                         AVL_Write,
    input  logic [15:0]                  AVL_WriteData,
    output logic [15:0]                  AVL_ReadData,
    input  logic                         VGA_VS,
    output logic [NUM_SPRITES-1:0][15:0] Sprite_X,
    output logic [NUM_SPRITES-1:0][15:0] Sprite_Y,
    output logic [NUM_SPRITES-1:0][15:0] Sprite_W,
    output logic [NUM_SPRITES-1:0][15:0] Sprite_H,
    output logic [NUM_SPRITES-1:0]       Sprite_Enable,
    input  logic [NUM_SPRITES-1:0]       Sprite_isObject,
    input  logic [NUM_SPRITES-1:0][15:0] Sprite_Pixel,
    output logic                         VGA_isObject,
    output logic [15:0]                  VGA_Pixel,
    output logic                         Frame_Commit
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    sprite_attr_t [NUM_SPRITES-1:0] shd_d, shd_q, act_d, act_q;
    logic [NUM_SPRITES-1:0]         shd_en_d, shd_en_q, act_en_d, act_en_q;
    logic                           pending_d, pending_q;
    logic                           commit_d, commit_q;
    logic [15:0]                    frame_cnt_d, frame_cnt_q;
    logic [15:0]                    rdata_d, rdata_q;
    logic                           vs_s1_q, vs_s2_q;
    logic                           frame_start_s;
    logic [NUM_SPRITES-1:0]         coll_s;
    logic                           coll_clr_s;
    logic [7:0]                     unused_fcnt_hi_s;

    logic [AW-3:0]                  grp_s;
    logic [1:0]                     fld_s;
    logic                           is_ctrl_s, is_status_s, is_coll_s, spr_hit_s;
    logic [IW-1:0]                  spr_idx_s;

    assign frame_start_s    = vs_s2_q & ~vs_s1_q;
    assign unused_fcnt_hi_s = frame_cnt_q[15:8];

    // Address decode: word groups of four, group 0 holds the control registers
    always_comb begin
        grp_s       = AVL_Address[AW-1:2];
        fld_s       = AVL_Address[1:0];
        is_ctrl_s   = (AVL_Address == AW'(REG_CTRL));
        is_status_s = (AVL_Address == AW'(REG_STATUS));
        is_coll_s   = (AVL_Address == AW'(REG_COLL));
        spr_hit_s   = (int'(grp_s) >= (REG_SPR_BASE / 4)) &&
                      (int'(grp_s) <  (REG_SPR_BASE / 4) + NUM_SPRITES);
        spr_idx_s   = IW'(int'(grp_s) - (REG_SPR_BASE / 4));
        coll_clr_s  = AVL_Read & is_coll_s;
    end

    // Register file, commit and frame counter next state
    always_comb begin
        shd_d       = shd_q;
        shd_en_d    = shd_en_q;
        act_d       = act_q;
        act_en_d    = act_en_q;
        pending_d   = pending_q;
        commit_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Commit copies the pre-write shadow; a same-cycle write lands in shadow only
        if (frame_start_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pending_q) begin
                act_d     = shd_q;
                act_en_d  = shd_en_q;
                pending_d = 1'b0;
                commit_d  = 1'b1;
            end else begin
                commit_d  = 1'b0;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        if (AVL_Write) begin
            if (is_ctrl_s) begin
                shd_en_d = AVL_WriteData[NUM_SPRITES-1:0];
                if (AVL_WriteData[CTRL_COMMIT_BIT]) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_d;
                end
            end else if (spr_hit_s) begin
                shd_d[spr_idx_s] = attr_put(shd_q[spr_idx_s], fld_s, AVL_WriteData);
            end else begin
                shd_d = shd_d;
            end
        end else begin
            shd_d = shd_d;
        end
    end

    // Registered read mux; data holds between reads
    always_comb begin
        rdata_d = rdata_q;
        if (AVL_Read) begin
            rdata_d = 16'h0000;
            if (is_ctrl_s) begin
                rdata_d[NUM_SPRITES-1:0] = shd_en_q;
            end else if (is_status_s) begin
                rdata_d = {frame_cnt_q[7:0], 7'h00, pending_q};
            end else if (is_coll_s) begin
                rdata_d[NUM_SPRITES-1:0] = coll_s;
            end else if (spr_hit_s) begin
                rdata_d = attr_get(shd_q[spr_idx_s], fld_s);
            end else begin
                rdata_d = 16'h0000;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shd_q       <= '0;
            shd_en_q    <= '0;
            act_q       <= '0;
            act_en_q    <= '0;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            frame_cnt_q <= 16'h0000;
            rdata_q     <= 16'h0000;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
        end else begin
            shd_q       <= shd_d;
            shd_en_q    <= shd_en_d;
            act_q       <= act_d;
            act_en_q    <= act_en_d;
            pending_q   <= pending_d;
            commit_q    <= commit_d;
            frame_cnt_q <= frame_cnt_d;
            rdata_q     <= rdata_d;
            vs_s1_q     <= VGA_VS;
            vs_s2_q     <= vs_s1_q;
        end
    end

    // Fan the active attributes out to the engines
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            Sprite_X[i] = act_q[i].x;
            Sprite_Y[i] = act_q[i].y;
            Sprite_W[i] = act_q[i].w;
            Sprite_H[i] = act_q[i].h;
        end
    end

    assign Sprite_Enable = act_en_q;
    assign Frame_Commit  = commit_q;
    assign AVL_ReadData  = rdata_q;

    vga_sprite_compositor #(
        .NUM_SPRITES(NUM_SPRITES)
    ) u_comp (
        .clk_i      (Clk),
        .rst_n_i    (Reset_n),
        .en_i       (act_en_q),
        .obj_i      (Sprite_isObject),
        .pixel_i    (Sprite_Pixel),
        .coll_clr_i (coll_clr_s),
        .is_object_o(VGA_isObject),
        .pixel_o    (VGA_Pixel),
        .coll_o     (coll_s)
    );

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Self-checking bench for vga_sprite_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register map and compositor.
module tb_vga_sprite_ctrl;

    localparam int NS = 8;
    localparam int AW = 6;

    logic                Clk = 1'b0;
    logic                Reset_n;
    logic [AW-1:0]       AVL_Address;
    logic                AVL_Read, AVL_Write;
    logic [15:0]         AVL_WriteData, AVL_ReadData;
    logic                VGA_VS;
    logic [NS-1:0][15:0] Sprite_X, Sprite_Y, Sprite_W, Sprite_H;
    logic [NS-1:0]       Sprite_Enable, Sprite_isObject;
    logic [NS-1:0][15:0] Sprite_Pixel;
    logic                VGA_isObject, Frame_Commit;
    logic [15:0]         VGA_Pixel;

    vga_sprite_ctrl #(.NUM_SPRITES(NS), .AW(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .AVL_Address(AVL_Address), .AVL_Read(AVL_Read),
        .AVL_Write(AVL_Write), .AVL_WriteData(AVL_WriteData), .AVL_ReadData(AVL_ReadData),
        .VGA_VS(VGA_VS), .Sprite_X(Sprite_X), .Sprite_Y(Sprite_Y), .Sprite_W(Sprite_W),
        .Sprite_H(Sprite_H), .Sprite_Enable(Sprite_Enable), .Sprite_isObject(Sprite_isObject),
        .Sprite_Pixel(Sprite_Pixel), .VGA_isObject(VGA_isObject), .VGA_Pixel(VGA_Pixel),
        .Frame_Commit(Frame_Commit)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_shd [NS][4];
    logic [15:0] m_act [NS][4];
    logic [NS-1:0] m_shd_en, m_act_en, m_coll;
    logic [15:0] m_fcnt, m_vpix, m_rdata;
    bit m_pend, m_commit, m_vobj, m_rdv, m_vs_last, m_vs_prev;

    function automatic logic [15:0] m_read(input int a);
        logic [15:0] v;
        v = 16'h0000;
        if (a == 0) v[NS-1:0] = m_shd_en;
        else if (a == 1) v = {m_fcnt[7:0], 7'h00, m_pend};
        else if (a == 2) begin
`ifdef VGA_SPRITE_COLLISION_EN
            v[NS-1:0] = m_coll;
`endif
        end
        else if (a >= 4 && a < 4 + 4 * NS) v = m_shd[(a - 4) / 4][(a - 4) % 4];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 4; f++) begin
                m_shd[i][f] = 16'h0000;
                m_act[i][f] = 16'h0000;
            end
        m_shd_en = '0; m_act_en = '0; m_coll = '0;
        m_fcnt = 16'h0000; m_vpix = 16'h0000; m_rdata = 16'h0000;
        m_pend = 1'b0; m_commit = 1'b0; m_vobj = 1'b0; m_rdv = 1'b0;
        m_vs_last = 1'b0; m_vs_prev = 1'b0;
    endtask

    task automatic m_step();
        logic [NS-1:0] hits;
        bit fs;
        int a;
        a    = int'(AVL_Address);
        fs   = m_vs_prev && !m_vs_last;
        hits = Sprite_isObject & m_act_en;
        m_vobj = (hits != '0);
        m_vpix = 16'h0000;
        for (int i = 0; i < NS; i++)
            if (hits[i]) begin
                m_vpix = Sprite_Pixel[i];
                break;
            end
        m_rdv = AVL_Read;
        if (AVL_Read) m_rdata = m_read(a);
        if (AVL_Read && a == 2) m_coll = '0;
`ifdef VGA_SPRITE_COLLISION_EN
        if ($countones(hits) >= 2) m_coll = m_coll | hits;
`endif
        m_commit = fs && m_pend;
        if (m_commit) begin
            m_act    = m_shd;
            m_act_en = m_shd_en;
            m_pend   = 1'b0;
        end
        if (fs) m_fcnt = m_fcnt + 16'd1;
        if (AVL_Write) begin
            if (a == 0) begin
                m_shd_en = AVL_WriteData[NS-1:0];
                if (AVL_WriteData[15]) m_pend = 1'b1;
            end else if (a >= 4 && a < 4 + 4 * NS) begin
                m_shd[(a - 4) / 4][(a - 4) % 4] = AVL_WriteData;
            end
        end
        m_vs_prev = m_vs_last;
        m_vs_last = VGA_VS;
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m_reset();
        else m_step();
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge Clk) begin
        if (chk_en && Reset_n) begin
            for (int i = 0; i < NS; i++) begin
                check($sformatf("X%0d", i), Sprite_X[i], m_act[i][0]);
                check($sformatf("Y%0d", i), Sprite_Y[i], m_act[i][1]);
                check($sformatf("W%0d", i), Sprite_W[i], m_act[i][2]);
                check($sformatf("H%0d", i), Sprite_H[i], m_act[i][3]);
            end
            check("enable", {8'h00, Sprite_Enable}, {8'h00, m_act_en});
            check("commit", {15'h0, Frame_Commit}, {15'h0, m_commit});
            check("vga_obj", {15'h0, VGA_isObject}, {15'h0, m_vobj});
            check("vga_pix", VGA_Pixel, m_vpix);
            if (m_rdv) check("rdata", AVL_ReadData, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic avl_write(input int a, input logic [15:0] d);
        AVL_Address   = AW'(a);
        AVL_WriteData = d;
        AVL_Write     = 1'b1;
        tick();
        AVL_Write     = 1'b0;
    endtask

    task automatic avl_read(input int a, output logic [15:0] d);
        AVL_Address = AW'(a);
        AVL_Read    = 1'b1;
        tick();
        AVL_Read    = 1'b0;
        d           = AVL_ReadData;
    endtask

    task automatic vs_frame(output int seen);
        seen   = 0;
        VGA_VS = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (Frame_Commit) seen++;
        end
        VGA_VS = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] d;
        int seen;
        int a;
        Reset_n = 1'b0; AVL_Address = '0; AVL_Read = 1'b0; AVL_Write = 1'b0;
        AVL_WriteData = 16'h0000; VGA_VS = 1'b1; Sprite_isObject = '0; Sprite_Pixel = '0;
        repeat (3) tick();
        check("rst_x0", Sprite_X[0], 16'h0000);
        check("rst_en", {8'h00, Sprite_Enable}, 16'h0000);
        check("rst_rdata", AVL_ReadData, 16'h0000);
        check("rst_commit", {15'h0, Frame_Commit}, 16'h0000);
        #1 Reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();

        // First commit
        avl_write(4, 16'd100); avl_write(5, 16'd50); avl_write(6, 16'd16); avl_write(7, 16'd16);
        avl_write(0, 16'h8001);
        avl_read(1, d);
        check("status_pending", d, 16'h0001);
        vs_frame(seen);
        check("commit_pulses", 16'(seen), 16'd1);
        check("x0_commit", Sprite_X[0], 16'd100);
        check("y0_commit", Sprite_Y[0], 16'd50);
        check("en_commit", {8'h00, Sprite_Enable}, 16'h0001);
        avl_read(1, d);
        check("status_after", d, 16'h0100);

        // Shadow write without commit
        avl_write(4, 16'd200);
        vs_frame(seen);
        check("no_commit_pulse", 16'(seen), 16'd0);
        vs_frame(seen);
        check("x0_held", Sprite_X[0], 16'd100);
        avl_read(4, d);
        check("x0_shadow", d, 16'd200);

        // Compositor priority
        avl_write(0, 16'h8007);
        vs_frame(seen);
        Sprite_Pixel[0] = 16'h1234; Sprite_Pixel[1] = 16'hF800; Sprite_Pixel[2] = 16'h07E0;
        Sprite_isObject = 8'b0000_0110;
        tick();
        check("comp_obj1", {15'h0, VGA_isObject}, 16'h0001);
        check("comp_pix1", VGA_Pixel, 16'hF800);
        avl_write(0, 16'h8004);
        vs_frame(seen);
        check("comp_pix2", VGA_Pixel, 16'h07E0);
        Sprite_isObject = '0;
        tick();
        check("comp_none_obj", {15'h0, VGA_isObject}, 16'h0000);
        check("comp_none_pix", VGA_Pixel, 16'h0000);

        // Collision register
        avl_write(2, 16'hFFFF);
        avl_write(0, 16'h8006);
        vs_frame(seen);
        Sprite_isObject = 8'b0000_0110;
        tick();
        Sprite_isObject = '0;
        tick();
        avl_read(2, d);
`ifdef VGA_SPRITE_COLLISION_EN
        check("coll_first", d, 16'h0006);
`else
        check("coll_first", d, 16'h0000);
`endif
        avl_read(2, d);
        check("coll_second", d, 16'h0000);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            AVL_Write = ($urandom_range(0, 3) == 0);
            AVL_Read  = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(36, 63) : $urandom_range(0, 35);
            if ($urandom_range(0, 5) == 0) a = 0;
            AVL_Address   = a[AW-1:0];
            AVL_WriteData = 16'($urandom);
            if ($urandom_range(0, 11) == 0) VGA_VS = ~VGA_VS;
            Sprite_isObject = NS'($urandom);
            for (int i = 0; i < NS; i++) Sprite_Pixel[i] = 16'($urandom);
            tick();
        end
        AVL_Write = 1'b0; AVL_Read = 1'b0; VGA_VS = 1'b1; Sprite_isObject = '0;
        repeat (4) tick();

        // Reset mid-frame with a commit pending
        avl_write(0, 16'h80FF);
        Sprite_isObject = 8'hFF;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        check("mrst_en", {8'h00, Sprite_Enable}, 16'h0000);
        check("mrst_obj", {15'h0, VGA_isObject}, 16'h0000);
        check("mrst_pix", VGA_Pixel, 16'h0000);
        check("mrst_commit", {15'h0, Frame_Commit}, 16'h0000);
        check("mrst_rdata", AVL_ReadData, 16'h0000);
        #3 Reset_n = 1'b1;
        Sprite_isObject = '0;
        repeat (2) tick();
        avl_read(1, d);
        check("mrst_status", d, 16'h0000);
        vs_frame(seen);
        check("mrst_no_commit", 16'(seen), 16'd0);
        check("mrst_en_after", {8'h00, Sprite_Enable}, 16'h0000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
